// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache.
// State encodings are plain 2-bit constants so legacy code comparing against
// raw state values keeps working. CNT_W sizes the fill byte counter, which
// runs 0..4: four address cycles plus the capture of the last byte.
package inst_cache_pkg;

  localparam int unsigned DEFAULT_INDEX_BITS = 6;
  localparam int unsigned CNT_W              = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MISS_REQ = 2'd1;
  localparam logic [1:0] ST_FILL     = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

endpackage

// File: rtl/inst_cache_store.sv
// Line storage for the direct-mapped instruction cache.
// Ports:
//   clk_in, rst_in   clock, async active-high reset (clears valid bits only)
//   rd_index/rd_tag  combinational lookup; hit = valid && tag match
//   rd_data          word stored at rd_index
//   we, wr_*         synchronous write of one line; sets its valid bit
module inst_cache_store #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  hit,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only ever read through its valid bit.
  always_ff @(posedge clk_in) begin
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign hit     = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_data = data[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory arbiter / byte RAM. Hits answer one cycle after the request; a
// miss requests the bus, reads four bytes little-endian and answers with a
// one-cycle ready pulse.
// Ports:
//   clk_in, rst_in            clock, async active-high reset
//   rdy_in                    global ready; low freezes every register
//   _clear                    flush: abandon any fill, drop pending response
//   _fetch_valid, _pc_in      fetch request (pc[1:0] ignored)
//   _inst_out, _inst_ready_out returned word and its one-cycle valid pulse
//   _mem_req, _mem_grant      arbiter handshake
//   _mem_a, _mem_din          byte RAM address / data (data one cycle later)
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _fetch_valid,
  input  logic [31:0] _pc_in,
  output logic [31:0] _inst_out,
  output logic        _inst_ready_out,
  output logic        _mem_req,
  input  logic        _mem_grant,
  output logic [31:0] _mem_a,
  input  logic [7:0]  _mem_din
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [29:0]      miss_word;   // pc[31:2] of the line being filled
  logic [23:0]      line;        // bytes 0..2 of the fill in progress
  logic [31:0]      fill_word;
  logic             hit;
  logic [31:0]      rd_data;
  logic             we;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^_pc_in[1:0];

  // Byte 3 arrives in the last fill cycle and goes straight into the word.
  assign fill_word = {_mem_din, line};

  // The write happens even when _clear arrives in the same cycle: only the
  // response is suppressed, the completed line is still good.
  assign we = rdy_in && (state == ST_FILL) && (cnt == CNT_W'(4));

  inst_cache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (_pc_in[INDEX_BITS+1:2]),
    .rd_tag   (_pc_in[31:INDEX_BITS+2]),
    .hit      (hit),
    .rd_data  (rd_data),
    .we       (we),
    .wr_index (miss_word[INDEX_BITS-1:0]),
    .wr_tag   (miss_word[29:INDEX_BITS]),
    .wr_data  (fill_word)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      miss_word       <= '0;
      line            <= '0;
      _inst_out       <= '0;
      _inst_ready_out <= 1'b0;
      _mem_req        <= 1'b0;
      _mem_a          <= '0;
    end else if (rdy_in) begin
      _inst_ready_out <= 1'b0;
      if (_clear) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        _mem_req <= 1'b0;
        _mem_a   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (_fetch_valid) begin
              if (hit) begin
                _inst_out       <= rd_data;
                _inst_ready_out <= 1'b1;
              end else begin
                miss_word <= _pc_in[31:2];
                state     <= ST_MISS_REQ;
                _mem_req  <= 1'b1;
              end
            end
          end
          ST_MISS_REQ: begin
            if (_mem_grant) begin
              state  <= ST_FILL;
              cnt    <= '0;
              _mem_a <= {miss_word, 2'b00};
            end
          end
          ST_FILL: begin
            // cnt k: address k is on the bus, byte k-1 is on _mem_din.
            case (cnt)
              CNT_W'(1): line[7:0]   <= _mem_din;
              CNT_W'(2): line[15:8]  <= _mem_din;
              CNT_W'(3): line[23:16] <= _mem_din;
              default: ;
            endcase
            if (cnt < CNT_W'(3)) begin
              _mem_a <= {miss_word, cnt[1:0] + 2'd1};
            end else begin
              _mem_a <= '0;
            end
            if (cnt == CNT_W'(4)) begin
              state           <= ST_RESP;
              cnt             <= '0;
              _inst_out       <= fill_word;
              _inst_ready_out <= 1'b1;
              _mem_req        <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RESP: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a table of fetches with expected latency and
// data, plus hand-written sequences for arbitration wait, flushes, rdy_in
// freeze and asynchronous reset mid-fill.
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        _clear;
  logic        _fetch_valid;
  logic [31:0] _pc_in;
  logic [31:0] _inst_out;
  logic        _inst_ready_out;
  logic        _mem_req;
  logic        _mem_grant;
  logic [31:0] _mem_a;
  logic [7:0]  _mem_din;

  logic        grant_en;
  logic [7:0]  ram [4096];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_in = ~clk_in;

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    ._clear          (_clear),
    ._fetch_valid    (_fetch_valid),
    ._pc_in          (_pc_in),
    ._inst_out       (_inst_out),
    ._inst_ready_out (_inst_ready_out),
    ._mem_req        (_mem_req),
    ._mem_grant      (_mem_grant),
    ._mem_a          (_mem_a),
    ._mem_din        (_mem_din)
  );

  assign _mem_grant = _mem_req & grant_en;

  // Byte RAM: registered read, frozen by the same rdy_in as the cache.
  always @(posedge clk_in) begin
    if (rdy_in) _mem_din <= ram[_mem_a[11:0]];
  end

  typedef struct {
    logic [31:0] pc;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [11:0] b;
    b = {pc[11:2], 2'b00};
    return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Continue counting cycles from 'start' until the ready pulse (bounded).
  task automatic wait_ready(input int start, output int lat);
    lat = start;
    while (!_inst_ready_out && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int exp_lat, input string name);
    int lat;
    _fetch_valid = 1'b1;
    _pc_in       = pc;
    tick();
    _fetch_valid = 1'b0;
    wait_ready(1, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " data"}, _inst_out, word_at(pc));
    chk({name, " mem_req at pulse"}, {31'd0, _mem_req}, 32'd0);
    tick();
  endtask

  initial begin
    int lat;
    bit seen;

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + (i >> 8) + 3);
    ram[12'h100] = 8'h13;
    ram[12'h101] = 8'h05;
    ram[12'h102] = 8'h10;
    ram[12'h103] = 8'h00;

    // index = pc[7:2]: 0x100 and 0x200 share index 0.
    vecs[0] = '{32'h0000_0100, 7, "cold miss 0x100"};
    vecs[1] = '{32'h0000_0100, 1, "hit 0x100"};
    vecs[2] = '{32'h0000_0104, 7, "miss 0x104"};
    vecs[3] = '{32'h0000_0104, 1, "hit 0x104"};
    vecs[4] = '{32'h0000_0200, 7, "conflict miss 0x200"};
    vecs[5] = '{32'h0000_0100, 7, "evicted re-miss 0x100"};
    vecs[6] = '{32'h0000_0200, 7, "evicted re-miss 0x200"};
    vecs[7] = '{32'h0000_0106, 1, "hit low bits ignored 0x106"};
    vecs[8] = '{32'h0000_0100, 7, "refill 0x100"};

    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _fetch_valid = 1'b0;
    _pc_in = '0; grant_en = 1'b1;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();

    chk("reset inst_out", _inst_out, 32'd0);
    chk("reset ready", {31'd0, _inst_ready_out}, 32'd0);
    chk("reset mem_req", {31'd0, _mem_req}, 32'd0);
    chk("reset mem_a", _mem_a, 32'd0);
    chk("cold word constant", word_at(32'h100), 32'h0010_0513);

    foreach (vecs[i]) do_fetch(vecs[i].pc, vecs[i].lat, vecs[i].name);

    // Back-to-back hits: one pulse per cycle.
    _fetch_valid = 1'b1; _pc_in = 32'h100;
    tick();
    chk("b2b first ready", {31'd0, _inst_ready_out}, 32'd1);
    chk("b2b first data", _inst_out, 32'h0010_0513);
    _pc_in = 32'h104;
    tick();
    _fetch_valid = 1'b0;
    chk("b2b second ready", {31'd0, _inst_ready_out}, 32'd1);
    chk("b2b second data", _inst_out, word_at(32'h104));
    chk("b2b mem_req", {31'd0, _mem_req}, 32'd0);
    tick();
    chk("b2b ready drops", {31'd0, _inst_ready_out}, 32'd0);

    // Arbitration wait: grant held off for 5 MISS_REQ cycles.
    grant_en = 1'b0;
    _fetch_valid = 1'b1; _pc_in = 32'h308;
    tick();
    _fetch_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (_inst_ready_out || _mem_a != 32'd0 || !_mem_req) seen = 1'b1;
      tick();
    end
    chk("arb wait quiet bus", {31'd0, seen}, 32'd0);
    grant_en = 1'b1;
    wait_ready(6, lat);
    chk("arb wait latency", 32'(lat), 32'd12);
    chk("arb wait data", _inst_out, word_at(32'h308));
    tick();

    // Flush during FILL cycle 2.
    _fetch_valid = 1'b1; _pc_in = 32'h40C;
    tick();
    _fetch_valid = 1'b0;
    repeat (3) tick();
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
    chk("flush ready", {31'd0, _inst_ready_out}, 32'd0);
    chk("flush mem_req", {31'd0, _mem_req}, 32'd0);
    chk("flush mem_a", _mem_a, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (_inst_ready_out) seen = 1'b1;
      tick();
    end
    chk("flush no pulse", {31'd0, seen}, 32'd0);
    do_fetch(32'h104, 1, "other line survives flush");
    do_fetch(32'h40C, 7, "flushed line re-miss");

    // Hit in the same cycle as _clear gives no response.
    _fetch_valid = 1'b1; _clear = 1'b1; _pc_in = 32'h104;
    tick();
    _fetch_valid = 1'b0; _clear = 1'b0;
    chk("clear on hit ready", {31'd0, _inst_ready_out}, 32'd0);
    tick();

    // Clear in the last FILL cycle: write kept, RESP suppressed.
    _fetch_valid = 1'b1; _pc_in = 32'h50;
    tick();
    _fetch_valid = 1'b0;
    repeat (5) tick();
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
    chk("late clear ready", {31'd0, _inst_ready_out}, 32'd0);
    chk("late clear mem_req", {31'd0, _mem_req}, 32'd0);
    tick();
    do_fetch(32'h50, 1, "late clear line written");

    // rdy_in low for 3 cycles in FILL shifts everything by 3.
    _fetch_valid = 1'b1; _pc_in = 32'h60;
    tick();
    _fetch_valid = 1'b0;
    repeat (2) tick();
    rdy_in = 1'b0;
    repeat (2) tick();
    chk("freeze holds mem_a", _mem_a, 32'h61);
    tick();
    rdy_in = 1'b1;
    wait_ready(6, lat);
    chk("freeze latency", 32'(lat), 32'd10);
    chk("freeze data", _inst_out, word_at(32'h60));
    tick();

    // Asynchronous reset mid-fill.
    _fetch_valid = 1'b1; _pc_in = 32'h70;
    tick();
    _fetch_valid = 1'b0;
    repeat (2) tick();
    #3 rst_in = 1'b1;
    #1;
    chk("async rst inst_out", _inst_out, 32'd0);
    chk("async rst ready", {31'd0, _inst_ready_out}, 32'd0);
    chk("async rst mem_req", {31'd0, _mem_req}, 32'd0);
    chk("async rst mem_a", _mem_a, 32'd0);
    #1 rst_in = 1'b0;
    tick();
    do_fetch(32'h100, 7, "miss after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
